// File: rtl/front_panel_loader.sv
`timescale 1ns/1ps
// Front-panel word loader: debounced hex-keypad style entry that issues one memory write per write key.
// Build macro PANEL_AUTOINC_EN: when defined, wr_addr advances by one after every completed write.
module front_panel_loader #(
  parameter int DB_CNT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  nibble_in,
  input  logic        key_enter,
  input  logic        key_addr,
  input  logic        key_write,
  input  logic        wr_ready,
  output logic        wr_valid,
  output logic [11:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [15:0] entry,
  output logic        busy
);

  localparam int CNT_W = $clog2(DB_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

  // Key index: 0 = enter, 1 = addr, 2 = write
  localparam int K_ENTER = 0;
  localparam int K_ADDR  = 1;
  localparam int K_WRITE = 2;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  logic [2:0]            raw;
  logic [2:0]            sync_p0;
  logic [2:0]            sync_p1;
  logic [2:0]            level_p2;
  logic [2:0]            level_p3;
  logic [2:0]            press_p4;
  logic [2:0][CNT_W-1:0] cnt;

  state_t state;
  state_t state_next;
  logic   do_enter;
  logic   do_addr;
  logic   do_write;
  logic   done;

  assign raw = {key_write, key_addr, key_enter};

  // Stage p0/p1: two-flop synchronizer per key
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounced level follows only after DB_CNT consecutive differing samples
  always_ff @(posedge clock) begin
    if (!reset) begin
      level_p2 <= '0;
      cnt      <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (sync_p1[k] == level_p2[k]) begin
          cnt[k] <= '0;
        end else if (cnt[k] == CNT_LAST) begin
          level_p2[k] <= sync_p1[k];
          cnt[k]      <= '0;
        end else begin
          cnt[k] <= cnt[k] + 1'b1;
        end
      end
    end
  end

  // Stage p3/p4: one-cycle press pulse on each debounced rising level
  always_ff @(posedge clock) begin
    if (!reset) begin
      level_p3 <= '0;
      press_p4 <= '0;
    end else begin
      level_p3 <= level_p2;
      press_p4 <= level_p2 & ~level_p3;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Presses are acted on only in IDLE; write outranks addr, addr outranks enter
  always_comb begin
    state_next = state;
    do_enter   = 1'b0;
    do_addr    = 1'b0;
    do_write   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (press_p4[K_WRITE]) begin
          do_write   = 1'b1;
          state_next = WRITE;
        end else if (press_p4[K_ADDR]) begin
          do_addr = 1'b1;
        end else if (press_p4[K_ENTER]) begin
          do_enter = 1'b1;
        end
      end
      WRITE: begin
        if (wr_valid && wr_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // Stage p5: entry word, address and write request registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      entry    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
    end else begin
      if (do_enter) begin
        entry <= {entry[11:0], nibble_in};
      end
      if (do_addr) begin
        wr_addr <= entry[11:0];
        entry   <= '0;
      end
      if (do_write) begin
        wr_data  <= entry;
        wr_valid <= 1'b1;
      end
      if (done) begin
        wr_valid <= 1'b0;
        entry    <= '0;
`ifdef PANEL_AUTOINC_EN
        wr_addr  <= wr_addr + 12'd1;
`else
        wr_addr  <= wr_addr;
`endif
      end
    end
  end

  assign busy = (state == WRITE);

endmodule

// File: tb/tb_front_panel_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for front_panel_loader: key actions update a word-level model and push expected writes.
module tb_front_panel_loader;

  localparam int DB     = 4;
  localparam int SETTLE = DB + 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  nibble_in;
  logic        key_enter;
  logic        key_addr;
  logic        key_write;
  logic        wr_ready;
  logic        wr_valid;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic [15:0] entry;
  logic        busy;

  always #5 clock = ~clock;

  front_panel_loader #(.DB_CNT(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .nibble_in (nibble_in),
    .key_enter (key_enter),
    .key_addr  (key_addr),
    .key_write (key_write),
    .wr_ready  (wr_ready),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .entry     (entry),
    .busy      (busy)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [27:0] exp_q[$];
  logic [27:0] head;
  logic [15:0] m_entry;
  logic [11:0] m_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: whenever a request is presented it must match the oldest expected write
  always @(negedge clock) begin
    if (reset && wr_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr_valid", 32'd1, 32'd0);
      end else begin
        head = exp_q[0];
        check("wr_addr", {20'd0, wr_addr}, {20'd0, head[27:16]});
        check("wr_data", {16'd0, wr_data}, {16'd0, head[15:0]});
        if (wr_ready) begin
          head = exp_q.pop_front();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      tick();
      wr_ready = 1'($urandom);
    end
    wr_ready = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_entry"}, {16'd0, entry}, {16'd0, m_entry});
    check({tag, "_addr"}, {20'd0, wr_addr}, {20'd0, m_addr});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic press_key(input int which, input logic [3:0] nib);
    nibble_in = nib;
    if (which == 0) key_enter = 1'b1;
    else            key_addr  = 1'b1;
    idle_cycles(SETTLE);
    key_enter = 1'b0;
    key_addr  = 1'b0;
    idle_cycles(SETTLE);
    if (which == 0) begin
      m_entry = {m_entry[11:0], nib};
    end else begin
      m_addr  = m_entry[11:0];
      m_entry = 16'h0;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!wr_valid && lat < 4 * SETTLE) begin
      tick();
      lat++;
      wr_ready = 1'($urandom);
    end
    check("wr_valid_rise", {31'd0, wr_valid}, 32'd1);
  endtask

  task automatic handshake(input int delay, input bit enter_during, output int held);
    held = 0;
    if (enter_during) begin
      wr_ready  = 1'b0;
      nibble_in = 4'($urandom);
      key_enter = 1'b1;
      repeat (SETTLE) begin
        held += int'(wr_valid);
        tick();
      end
      key_enter = 1'b0;
      repeat (SETTLE) begin
        held += int'(wr_valid);
        tick();
      end
    end
    for (int i = 0; i <= delay; i++) begin
      wr_ready = (i == delay);
      held += int'(wr_valid);
      tick();
    end
    wr_ready = 1'b0;
    check("wr_valid_after_done", {31'd0, wr_valid}, 32'd0);
  endtask

  task automatic finish_write_model();
    m_entry = 16'h0;
`ifdef PANEL_AUTOINC_EN
    m_addr = m_addr + 12'd1;
`endif
  endtask

  task automatic do_write(input int delay, input bit enter_during);
    int lat;
    int held;
    exp_q.push_back({m_addr, m_entry});
    key_write = 1'b1;
    wait_valid(lat);
    check("latency", lat, DB + 4);
    handshake(delay, enter_during, held);
    check("wr_valid_cycles", held, delay + 1 + (enter_during ? 2 * SETTLE : 0));
    key_write = 1'b0;
    idle_cycles(SETTLE);
    finish_write_model();
    check_state("after_write");
  endtask

  initial begin
    int lat;
    int held;
    int r;
    reset     = 1'b0;
    key_enter = 1'b0;
    key_addr  = 1'b0;
    key_write = 1'b0;
    nibble_in = 4'h0;
    wr_ready  = 1'b0;
    m_entry   = 16'h0;
    m_addr    = 12'h0;
    repeat (3) tick();
    check("reset_entry", {16'd0, entry}, 32'd0);
    check("reset_addr", {20'd0, wr_addr}, 32'd0);
    check("reset_data", {16'd0, wr_data}, 32'd0);
    check("reset_valid", {31'd0, wr_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    tick();

    // Nibble shifting
    press_key(0, 4'h1);
    press_key(0, 4'h2);
    press_key(0, 4'h3);
    press_key(0, 4'h4);
    check("entry_1234", {16'd0, entry}, 32'h1234);
    press_key(0, 4'hA);
    check("entry_234A", {16'd0, entry}, 32'h234A);
    check_state("shift");

    // Bouncing enter key yields exactly one shift
    nibble_in = 4'h5;
    for (int b = 0; b < 2; b++) begin
      key_enter = 1'b1;
      idle_cycles(2);
      key_enter = 1'b0;
      idle_cycles(2);
    end
    key_enter = 1'b1;
    idle_cycles(10);
    key_enter = 1'b0;
    idle_cycles(SETTLE);
    m_entry = {m_entry[11:0], 4'h5};
    check("bounce_entry", {16'd0, entry}, 32'h34A5);
    check_state("bounce");

    // Write at top address, held 6 cycles
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_entry = 16'h0;
    m_addr  = 12'h0;
    press_key(0, 4'h0);
    press_key(0, 4'hF);
    press_key(0, 4'hF);
    press_key(0, 4'hF);
    check("entry_0FFF", {16'd0, entry}, 32'h0FFF);
    press_key(1, 4'h0);
    check("addr_FFF", {20'd0, wr_addr}, 32'hFFF);
    press_key(0, 4'hB);
    press_key(0, 4'hE);
    press_key(0, 4'hE);
    press_key(0, 4'hF);
    check("entry_BEEF", {16'd0, entry}, 32'hBEEF);
    do_write(5, 1'b0);
`ifdef PANEL_AUTOINC_EN
    check("addr_after_wrap", {20'd0, wr_addr}, 32'h000);
`else
    check("addr_after_wrap", {20'd0, wr_addr}, 32'hFFF);
`endif

    // Write and addr pressed together: only the write acts
    press_key(0, 4'h7);
    press_key(1, 4'h0);
    press_key(0, 4'hC);
    press_key(0, 4'h3);
    key_addr = 1'b1;
    do_write(1, 1'b0);
    key_addr = 1'b0;
    idle_cycles(SETTLE);
    check_state("write_and_addr");

    // Enter pressed while a write is pending is discarded
    press_key(0, 4'h9);
    do_write(2, 1'b1);
    idle_cycles(SETTLE);
    check_state("enter_in_write");

    // Reset mid-write, write key held through reset release
    press_key(0, 4'h6);
    exp_q.push_back({m_addr, m_entry});
    key_write = 1'b1;
    wait_valid(lat);
    check("latency_abort", lat, DB + 4);
    wr_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("abort_valid", {31'd0, wr_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_entry", {16'd0, entry}, 32'd0);
    check("abort_addr", {20'd0, wr_addr}, 32'd0);
    check("abort_data", {16'd0, wr_data}, 32'd0);
    reset = 1'b1;
    exp_q.delete();
    m_entry = 16'h0;
    m_addr  = 12'h0;
    exp_q.push_back({m_addr, m_entry});
    wait_valid(lat);
    check("latency_after_reset", lat, DB + 4);
    handshake(0, 1'b0, held);
    check("held_after_reset", held, 1);
    key_write = 1'b0;
    idle_cycles(SETTLE);
    finish_write_model();
    check_state("after_reset_write");

    // Random key actions
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      press_key(0, 4'($urandom));
      else if (r < 8) press_key(1, 4'h0);
      else            do_write($urandom_range(0, 3), 1'b0);
      check_state("rand");
    end

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
